// File: rtl/red_pitaya_pwm_dac.sv
// Multi-channel PWM DAC with sigma-style dither of the fractional code bits.
// Each channel drives a PWM whose duty is the upper PW code bits; the lower
// DW bits stretch the pulse by one clock in a bit-reversed pattern across
// 2^DW periods so the long-term average resolves the full PW+DW-bit code.
// Codes are taken either from a bus register or from a signed input sample
// and are only adopted at period boundaries so a pulse is never cut short.
module red_pitaya_pwm_dac #(
  parameter int NCH = 4,   // number of PWM channels (1..8)
  parameter int IW  = 14,  // signed input sample width, >= PW+DW
  parameter int PW  = 8,   // duty bits, period is 2^PW clocks
  parameter int DW  = 4    // dither bits, pattern spans 2^DW periods
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [NCH*IW-1:0] pwm_i,
  output logic [NCH-1:0]  pwm_o,
  input  logic [31:0]     sys_addr,
  input  logic [31:0]     sys_wdata,
  input  logic [3:0]      sys_sel,
  input  logic            sys_wen,
  input  logic            sys_ren,
  output logic [31:0]     sys_rdata,
  output logic            sys_err,
  output logic            sys_ack
);

  localparam int CW = PW + DW;

  logic [PW-1:0]  cnt_reg;
  logic [DW-1:0]  cyc_reg;
  logic [DW-1:0]  cyc_rev;
  logic           wrap;

  logic [CW-1:0]  val_reg  [NCH];
  logic [CW-1:0]  act_reg  [NCH];
  logic [CW-1:0]  sel_code [NCH];
  logic [NCH-1:0] mode_reg;
  logic [NCH-1:0] en_reg;
  logic [NCH-1:0] pwm_next;

  logic [19:0]    addr;
  logic [31:0]    rdata_next;

  // Byte selects, the undecoded address bits and the input bits below the
  // code resolution carry no information for this block.
  logic           unused_bits;
  assign unused_bits = ^{sys_sel, sys_addr[31:20], sys_wdata, pwm_i};

  assign addr = sys_addr[19:0];
  assign wrap = &cnt_reg;

  // Bit-reversed dither counter spreads the extra clocks evenly over the window.
  generate
    for (genvar gi = 0; gi < DW; gi++) begin : g_rev
      assign cyc_rev[gi] = cyc_reg[DW-1-gi];
    end
  endgenerate

  // Per-channel code selection and threshold compare.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [CW-1:0] in_code;
      logic [PW:0]   thr;
      logic          extra;

      // Offset-binary conversion: flip the sign bit, keep the top CW-1 magnitude bits.
      assign in_code = {~pwm_i[gi*IW + IW - 1], pwm_i[gi*IW + IW - 2 -: CW - 1]};
      assign sel_code[gi] = mode_reg[gi] ? in_code : val_reg[gi];

      // Threshold is one bit wider so a full-scale code can hold the output high all period.
      assign extra = (cyc_rev < act_reg[gi][DW-1:0]);
      assign thr   = {1'b0, act_reg[gi][CW-1:DW]} + {{PW{1'b0}}, extra};
      assign pwm_next[gi] = en_reg[gi] & ({1'b0, cnt_reg} < thr);
    end
  endgenerate

  // Free-running period counter and dither counter advancing at each period wrap.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_reg <= '0;
      cyc_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
      if (wrap) begin
        cyc_reg <= cyc_reg + 1'b1;
      end
    end
  end

  // Bus-writable configuration: per-channel codes, source select and enables.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NCH; i++) begin
        val_reg[i] <= '0;
      end
      mode_reg <= '0;
      en_reg   <= '0;
    end else if (sys_wen) begin
      for (int i = 0; i < NCH; i++) begin
        if (addr == 20'(4 * i)) begin
          val_reg[i] <= sys_wdata[CW-1:0];
        end
      end
      if (addr == 20'h00040) begin
        mode_reg <= sys_wdata[NCH-1:0];
      end
      if (addr == 20'h00044) begin
        en_reg <= sys_wdata[NCH-1:0];
      end
    end
  end

  // Adopt the selected code only at the period wrap so every pulse is complete.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NCH; i++) begin
        act_reg[i] <= '0;
      end
    end else if (wrap) begin
      for (int i = 0; i < NCH; i++) begin
        act_reg[i] <= sel_code[i];
      end
    end
  end

  // Registered PWM outputs, one clock behind the period counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pwm_o <= '0;
    end else begin
      pwm_o <= pwm_next;
    end
  end

  // Read data mux; anything not decoded reads as zero.
  always_comb begin
    rdata_next = '0;
    for (int i = 0; i < NCH; i++) begin
      if (addr == 20'(4 * i)) begin
        rdata_next = 32'(val_reg[i]);
      end
      if (addr == 20'(32 + 4 * i)) begin
        rdata_next = 32'(act_reg[i]);
      end
    end
    if (addr == 20'h00040) begin
      rdata_next = 32'(mode_reg);
    end
    if (addr == 20'h00044) begin
      rdata_next = 32'(en_reg);
    end
    if (addr == 20'h00048) begin
      rdata_next = {8'd0, 8'(NCH), 8'(PW), 8'(DW)};
    end
  end

  // Bus response: every strobe is acknowledged one clock later, never an error.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sys_ack   <= 1'b0;
      sys_err   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack <= sys_wen | sys_ren;
      sys_err <= 1'b0;
      if (sys_ren) begin
        sys_rdata <= rdata_next;
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_pwm_dac.sv
// Self-checking bench for red_pitaya_pwm_dac (NCH=4, IW=14, PW=8, DW=4).
// Expected bus read data and per-period high-time counts are queued when the
// stimulus is applied and popped when the DUT produces the matching result.
module tb_red_pitaya_pwm_dac;

  localparam int NCH = 4;
  localparam int IW  = 14;
  localparam int PW  = 8;
  localparam int DW  = 4;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NCH*IW-1:0] pwm_i;
  logic [NCH-1:0]    pwm_o;
  logic [31:0]       sys_addr;
  logic [31:0]       sys_wdata;
  logic [3:0]        sys_sel;
  logic              sys_wen;
  logic              sys_ren;
  logic [31:0]       sys_rdata;
  logic              sys_err;
  logic              sys_ack;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  int          pq[$];
  int          meas_cnt[0:31];

  // Reference timebase: period slot and dither index expected from reset release.
  logic [7:0]  tb_cnt;
  logic [3:0]  tb_cyc;

  always #5 clk = ~clk;

  red_pitaya_pwm_dac #(.NCH(NCH), .IW(IW), .PW(PW), .DW(DW)) dut (
    .clk_i    (clk),
    .rstn_i   (rstn),
    .pwm_i    (pwm_i),
    .pwm_o    (pwm_o),
    .sys_addr (sys_addr),
    .sys_wdata(sys_wdata),
    .sys_sel  (sys_sel),
    .sys_wen  (sys_wen),
    .sys_ren  (sys_ren),
    .sys_rdata(sys_rdata),
    .sys_err  (sys_err),
    .sys_ack  (sys_ack)
  );

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tb_cnt <= 8'd0;
      tb_cyc <= 4'd0;
    end else begin
      tb_cnt <= tb_cnt + 8'd1;
      if (tb_cnt == 8'hFF) tb_cyc <= tb_cyc + 4'd1;
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time exceeded, bad=%0d", bad + 1);
    $fatal(1, "watchdog");
  end

  function automatic int brev4(input int c);
    logic [3:0] v;
    logic [3:0] r;
    v = c[3:0];
    for (int k = 0; k < 4; k++) r[k] = v[3-k];
    return int'(r);
  endfunction

  // All bus tasks start and end on a falling edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    @(negedge clk);
    sys_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output int lat);
    sys_addr = a; sys_ren = 1'b1;
    @(negedge clk);
    sys_ren = 1'b0;
    lat = 1;
    while (!sys_ack && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (!sys_ack) lat = 99;
    d = sys_rdata;
  endtask

  task automatic settle();
    @(negedge clk);
    while (tb_cnt != 8'd1) @(negedge clk);
  endtask

  // Count high samples of one channel over whole periods, starting at the next period start.
  task automatic measure(input int ch, input int nper, input bit aligned);
    settle();
    if (aligned) while (tb_cyc != 4'd0) repeat (256) @(negedge clk);
    for (int p = 0; p < nper; p++) begin
      meas_cnt[p] = 0;
      for (int s = 0; s < 256; s++) begin
        if (pwm_o[ch]) meas_cnt[p]++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d, e;
    int lat;
    repeat (3) @(negedge clk);
    total++; if (pwm_o !== 4'h0) begin bad++; $display("FAIL rst_pwm: got %h want 0", pwm_o); end
    total++; if (sys_ack !== 1'b0) begin bad++; $display("FAIL rst_ack: got %b want 0", sys_ack); end
    total++; if (sys_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", sys_rdata); end
    rstn = 1'b1;
    exp_q.push_back(32'h0); bus_read(32'h40, d, lat); e = exp_q.pop_front();
    total++; if (lat != 1 || d !== e) begin bad++; $display("FAIL rst_mode_rd: got %h lat=%0d want %h lat=1", d, lat, e); end
    $display("reset released, MODE read %h", d);
  endtask

  task automatic test_bus_map();
    logic [31:0] d, e;
    int lat;
    exp_q.push_back(32'h0); bus_read(32'h100, d, lat); e = exp_q.pop_front();
    total++; if (lat != 1 || d !== e) begin bad++; $display("FAIL unmapped_rd: got %h lat=%0d want %h lat=1", d, lat, e); end
    total++; if (sys_err !== 1'b0) begin bad++; $display("FAIL unmapped_err: got %b want 0", sys_err); end
    $display("read 0x100 -> %h lat=%0d", d, lat);
    exp_q.push_back(32'h00040804); bus_read(32'h48, d, lat); e = exp_q.pop_front();
    total++; if (lat != 1 || d !== e) begin bad++; $display("FAIL param_rd: got %h lat=%0d want %h", d, lat, e); end
    $display("read 0x48 -> %h", d);
    bus_write(32'h48, 32'h1234_5678);
    total++; if (sys_ack !== 1'b1) begin bad++; $display("FAIL wr_ack: got %b want 1", sys_ack); end
    bus_write(32'h10, 32'h0000_0ABC);
    bus_write(32'h20, 32'h0000_0FFF);
    exp_q.push_back(32'h00040804); bus_read(32'h48, d, lat); e = exp_q.pop_front();
    total++; if (lat != 1 || d !== e) begin bad++; $display("FAIL param_ro: got %h want %h", d, e); end
    exp_q.push_back(32'h0); bus_read(32'h10, d, lat); e = exp_q.pop_front();
    total++; if (lat != 1 || d !== e) begin bad++; $display("FAIL val4_rd: got %h want %h", d, e); end
    exp_q.push_back(32'h0); bus_read(32'h20, d, lat); e = exp_q.pop_front();
    total++; if (lat != 1 || d !== e) begin bad++; $display("FAIL act0_ro: got %h want %h", d, e); end
    $display("RO/unmapped writes ignored check done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, e;
    int lat;
    bus_write(32'h40, 32'hFFFF_FFF5);
    bus_write(32'h44, 32'h0000_000A);
    bus_write(32'h0C, 32'hFFFF_F123);
    exp_q.push_back(32'h5); exp_q.push_back(32'hA); exp_q.push_back(32'h123);
    bus_read(32'h40, d, lat); e = exp_q.pop_front();
    total++; if (lat != 1 || d !== e) begin bad++; $display("FAIL b2b_mode: got %h want %h", d, e); end
    bus_read(32'h44, d, lat); e = exp_q.pop_front();
    total++; if (lat != 1 || d !== e) begin bad++; $display("FAIL b2b_en: got %h want %h", d, e); end
    bus_read(32'h0C, d, lat); e = exp_q.pop_front();
    total++; if (lat != 1 || d !== e) begin bad++; $display("FAIL b2b_val3: got %h want %h", d, e); end
    $display("back-to-back writes/reads: VAL3=%h", d);
    bus_write(32'h40, 32'h0);
    bus_write(32'h44, 32'h0);
  endtask

  task automatic test_half_duty();
    logic [31:0] d, e;
    int lat, x;
    bus_write(32'h00, 32'hABCD_E800);
    bus_write(32'h44, 32'h1);
    exp_q.push_back(32'h800); bus_read(32'h00, d, lat); e = exp_q.pop_front();
    total++; if (lat != 1 || d !== e) begin bad++; $display("FAIL val0_rd: got %h want %h", d, e); end
    settle();
    pq.push_back(128); pq.push_back(128);
    measure(0, 2, 1'b0);
    for (int p = 0; p < 2; p++) begin
      x = pq.pop_front();
      total++; if (meas_cnt[p] != x) begin bad++; $display("FAIL half_period%0d: got %0d want %0d", p, meas_cnt[p], x); end
      $display("half duty period %0d high=%0d", p, meas_cnt[p]);
    end
    exp_q.push_back(32'h800); bus_read(32'h20, d, lat); e = exp_q.pop_front();
    total++; if (lat != 1 || d !== e) begin bad++; $display("FAIL act0_rd: got %h want %h", d, e); end
  endtask

  task automatic test_dither();
    int x, sum, n129;
    bus_write(32'h00, 32'h805);
    settle();
    for (int c = 0; c < 16; c++) pq.push_back(128 + ((brev4(c) < 5) ? 1 : 0));
    measure(0, 16, 1'b1);
    sum = 0; n129 = 0;
    for (int p = 0; p < 16; p++) begin
      x = pq.pop_front();
      sum += meas_cnt[p];
      if (meas_cnt[p] == 129) n129++;
      total++; if (meas_cnt[p] != x) begin bad++; $display("FAIL dither_p%0d: got %0d want %0d", p, meas_cnt[p], x); end
    end
    total++; if (sum != 2053) begin bad++; $display("FAIL dither_sum: got %0d want 2053", sum); end
    total++; if (n129 != 5) begin bad++; $display("FAIL dither_n129: got %0d want 5", n129); end
    $display("dither 0x805: total high=%0d periods@129=%0d", sum, n129);
  endtask

  task automatic test_mode_input();
    logic [31:0] d, e;
    int lat, x, sum;
    bus_write(32'h44, 32'h2);
    bus_write(32'h40, 32'h2);
    pwm_i[1*IW +: IW] = 14'h2000;
    settle();
    pq.push_back(0); pq.push_back(0);
    measure(1, 2, 1'b0);
    for (int p = 0; p < 2; p++) begin
      x = pq.pop_front();
      total++; if (meas_cnt[p] != x) begin bad++; $display("FAIL in_min_p%0d: got %0d want %0d", p, meas_cnt[p], x); end
    end
    $display("pwm_i=0x2000 -> high=%0d", meas_cnt[0]);
    pwm_i[1*IW +: IW] = 14'h1FFF;
    settle();
    for (int c = 0; c < 16; c++) pq.push_back(255 + ((brev4(c) < 15) ? 1 : 0));
    measure(1, 16, 1'b1);
    sum = 0;
    for (int p = 0; p < 16; p++) begin
      x = pq.pop_front();
      sum += meas_cnt[p];
      total++; if (meas_cnt[p] != x) begin bad++; $display("FAIL in_max_p%0d: got %0d want %0d", p, meas_cnt[p], x); end
    end
    total++; if (sum != 4095) begin bad++; $display("FAIL in_max_sum: got %0d want 4095", sum); end
    $display("pwm_i=0x1FFF -> total high=%0d", sum);
    exp_q.push_back(32'hFFF); bus_read(32'h24, d, lat); e = exp_q.pop_front();
    total++; if (lat != 1 || d !== e) begin bad++; $display("FAIL act1_rd: got %h want %h", d, e); end
  endtask

  task automatic test_update_timing();
    int x;
    bus_write(32'h40, 32'h0);
    bus_write(32'h44, 32'h1);
    bus_write(32'h00, 32'h400);
    settle();
    settle();
    pq.push_back(64); pq.push_back(128);
    fork
      measure(0, 2, 1'b0);
      begin
        settle();
        while (tb_cnt != 8'd100) @(negedge clk);
        bus_write(32'h00, 32'h800);
      end
    join
    for (int p = 0; p < 2; p++) begin
      x = pq.pop_front();
      total++; if (meas_cnt[p] != x) begin bad++; $display("FAIL mid_wr_p%0d: got %0d want %0d", p, meas_cnt[p], x); end
      $display("write at cnt=100, period %0d high=%0d", p, meas_cnt[p]);
    end
    pq.push_back(128); pq.push_back(128); pq.push_back(192);
    fork
      measure(0, 3, 1'b0);
      begin
        settle();
        while (tb_cnt != 8'd255) @(negedge clk);
        bus_write(32'h00, 32'hC00);
      end
    join
    for (int p = 0; p < 3; p++) begin
      x = pq.pop_front();
      total++; if (meas_cnt[p] != x) begin bad++; $display("FAIL wrap_wr_p%0d: got %0d want %0d", p, meas_cnt[p], x); end
      $display("write on wrap edge, period %0d high=%0d", p, meas_cnt[p]);
    end
  endtask

  task automatic test_enable_clear();
    bus_write(32'h00, 32'hFF0);
    settle();
    settle();
    while (tb_cnt != 8'd10) @(negedge clk);
    bus_write(32'h44, 32'h0);
    total++; if (pwm_o[0] !== 1'b1) begin bad++; $display("FAIL en_clr_edge: got %b want 1", pwm_o[0]); end
    @(negedge clk);
    total++; if (pwm_o[0] !== 1'b0) begin bad++; $display("FAIL en_clr_next: got %b want 0", pwm_o[0]); end
    $display("EN cleared: pwm_o[0]=%b one clock later", pwm_o[0]);
    bus_write(32'h44, 32'h1);
    settle();
    while (tb_cnt != 8'd255) @(negedge clk);
    total++; if (pwm_o[0] !== 1'b1) begin bad++; $display("FAIL align_slot254: got %b want 1", pwm_o[0]); end
    @(negedge clk);
    total++; if (pwm_o[0] !== 1'b0) begin bad++; $display("FAIL align_slot255: got %b want 0", pwm_o[0]); end
    $display("re-enabled: slot alignment checked");
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, e;
    int lat, x;
    bus_write(32'h00, 32'h800);
    settle();
    settle();
    while (tb_cnt != 8'd20) @(negedge clk);
    total++; if (pwm_o[0] !== 1'b1) begin bad++; $display("FAIL pre_rst_high: got %b want 1", pwm_o[0]); end
    #2 rstn = 1'b0;
    #1;
    total++; if (pwm_o !== 4'h0) begin bad++; $display("FAIL async_rst_pwm: got %h want 0", pwm_o); end
    $display("mid-period reset: pwm_o=%h", pwm_o);
    @(negedge clk);
    rstn = 1'b1;
    exp_q.push_back(32'h0); bus_read(32'h00, d, lat); e = exp_q.pop_front();
    total++; if (lat != 1 || d !== e) begin bad++; $display("FAIL rst_val0: got %h want %h", d, e); end
    exp_q.push_back(32'h0); bus_read(32'h44, d, lat); e = exp_q.pop_front();
    total++; if (lat != 1 || d !== e) begin bad++; $display("FAIL rst_en: got %h want %h", d, e); end
    exp_q.push_back(32'h0); bus_read(32'h20, d, lat); e = exp_q.pop_front();
    total++; if (lat != 1 || d !== e) begin bad++; $display("FAIL rst_act0: got %h want %h", d, e); end
    pq.push_back(0);
    measure(0, 1, 1'b0);
    x = pq.pop_front();
    total++; if (meas_cnt[0] != x) begin bad++; $display("FAIL post_rst_pwm: got %0d want %0d", meas_cnt[0], x); end
    $display("after reset: VAL0/EN/ACT0 read zero, high=%0d", meas_cnt[0]);
  endtask

  initial begin
    rstn      = 1'b0;
    pwm_i     = '0;
    sys_addr  = '0;
    sys_wdata = '0;
    sys_sel   = 4'hF;
    sys_wen   = 1'b0;
    sys_ren   = 1'b0;
    test_reset();
    test_bus_map();
    test_back_to_back();
    test_half_duty();
    test_dither();
    test_mode_input();
    test_update_timing();
    test_enable_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/red_pitaya_pwm_dac.md
RED_PITAYA_PWM_DAC -- requirements
Module: red_pitaya_pwm_dac

Interface
REQ-001 Parameter NCH, default 4, number of PWM channels, range 1..8.
REQ-002 Parameter IW, default 14, signed input sample width; IW SHALL be >= PW+DW.
REQ-003 Parameter PW, default 8, duty bits; PWM period is 2^PW clocks.
REQ-004 Parameter DW, default 4, dither bits; dither sequence spans 2^DW periods.
REQ-005 Port clk_i  in  1  clock; one clock, all logic on its rising edge.
REQ-006 Port rstn_i  in  1  reset, asynchronous, active-low.
REQ-007 Port pwm_i  in  NCH*IW  signed samples; channel n occupies bits [n*IW +: IW].
REQ-008 Port pwm_o  out  NCH  registered PWM outputs.
REQ-009 Port sys_addr  in  32  bus address; only bits [19:0] decoded.
REQ-010 Port sys_wdata  in  32  bus write data.
REQ-011 Port sys_sel  in  4  byte select; ignored, all writes full-word.
REQ-012 Ports sys_wen, sys_ren  in  1 each  single-cycle write / read strobes.
REQ-013 Ports sys_rdata (out, 32), sys_err (out, 1), sys_ack (out, 1)  bus response.

Function
REQ-014 Register map: 0x00+4n VAL[n] RW (PW+DW bits, wdata[PW+DW-1:0]); 0x20+4n ACT[n] RO (latched code); 0x40 MODE RW (bit n: 0=VAL, 1=pwm_i); 0x44 EN RW (bit n enables channel n); 0x48 PARAM RO = {8'd0, NCH[7:0], PW[7:0], DW[7:0]}.
REQ-015 Bus: sys_ack SHALL be sys_wen|sys_ren registered (one-cycle latency) for every address; sys_err always 0; unmapped or n>=NCH reads return 0; writes to RO/unmapped addresses ignored; upper unused read bits zero.
REQ-016 Input code: code = {~in[IW-1], in[IW-2 : IW-PW-DW]} (offset-binary, truncated to PW+DW bits).
REQ-017 Selected code per channel = MODE[n] ? input code : VAL[n]; split into D = code[PW+DW-1:DW], F = code[DW-1:0].
REQ-018 Period counter cnt: PW bits, free-running, increments every clock, wraps 2^PW-1 -> 0.
REQ-019 Dither counter cyc: DW bits, increments on each cnt wrap, wraps 2^DW-1 -> 0.
REQ-020 On the edge where cnt goes 2^PW-1 -> 0, each channel SHALL latch its selected code into ACT[n]; ACT changes at no other time (glitch-free update).
REQ-021 Code latched at that edge SHALL be the value present before the edge; a VAL/MODE write on the same edge applies at the following period.
REQ-022 Extra bit E = (bitreverse(cyc) < F_act), cyc being the value during the period; threshold T = D_act + E computed in PW+1 bits.
REQ-023 pwm_o[n] <= EN[n] & (cnt < T): output lags cnt by one clock; high for exactly T clocks per period.
REQ-024 Boundaries: T=0 -> constant low; T=2^PW -> constant high whole period; EN cleared -> low from the next clock, counters unaffected.
REQ-025 Over any aligned 2^DW-period window the high-time total SHALL equal D*2^DW + F for constant code.

Reset
REQ-026 rstn_i low SHALL immediately clear cnt, cyc, VAL, ACT, MODE, EN, pwm_o, sys_ack, sys_err, sys_rdata to zero, independent of clk_i.
REQ-027 After deassertion cnt starts at 0 on the first clock; reset mid-period aborts the period with no partial pulse retained.

Verification (PW=8, DW=4, NCH=4)
REQ-028 Assert rstn_i mid-period with ch0 high -> pwm_o=0 before next clock edge; read 0x00 and 0x44 return 0.
REQ-029 Write VAL[0]=0x800, EN=0x1 -> from second period, ch0 high exactly 128 of 256 clocks every period; ACT[0] reads 0x800.
REQ-030 Write VAL[0]=0x805 -> over 16 aligned periods 5 have 129 high clocks, 11 have 128; total 2053.
REQ-031 MODE=0x2, EN=0x2, pwm_i ch1=14'h2000 -> ch1 constant low; then 14'h1FFF -> code 0xFFF, 15 periods fully high, 1 period 255 high.
REQ-032 Write VAL[0] at cnt=100 -> current period unchanged, new duty from next cnt=0; write landing on the wrap edge applies one period later.
REQ-033 Read 0x100 -> sys_ack one clock later, sys_rdata=0, sys_err=0; read 0x48 -> 0x00040804.
